// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared constants and fetch-state encoding for the MIPS front end.
// Revision : 1.0
// ============================================================================
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int unsigned PC_INC    = 4;
    localparam int unsigned OPCODE_HI = 31;
    localparam int unsigned OPCODE_LO = 26;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetchState_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_skid_buf
// Brief    : One-entry {instr, pc4} holding register; clear beats load beats unload.
// Revision : 1.0
// ============================================================================
module fetch_skid_buf
    import mips_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_unload,
    input  logic            i_clear,
    input  logic [31:0]     i_instr,
    input  logic [PC_W-1:0] i_pc4,
    output logic            o_full,
    output logic [31:0]     o_instr,
    output logic [PC_W-1:0] o_pc4
);

    logic            r_full;
    logic [31:0]     r_instr;
    logic [PC_W-1:0] r_pc4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full  <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc4   <= '0;
        end else if (i_clear) begin
            r_full  <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (i_load) begin
            r_full  <= 1'b1;
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
        end else if (i_unload) begin
            r_full  <= 1'b0;
        end
    end

    assign o_full  = r_full;
    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_stage
// Brief    : PC owner, req/ack instruction fetch and IF/ID register with stall
//            skid buffer and redirect drain. FETCH_PERF_EN adds perf counters.
// Revision : 1.0
// ============================================================================
module instr_fetch_stage
    import mips_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect_en,
    input  logic [PC_W-1:0] redirect_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_bubbles,
`endif
    output logic [31:0]     if_id_instr,
    output logic [PC_W-1:0] if_id_pc4,
    output logic            if_id_valid
);

    localparam logic [PC_W-1:0] c_alignMask = ~(PC_W'(3));

    fetchState_t     r_state, w_nextState;
    logic [PC_W-1:0] r_fetchPc, w_nextFetchPc;
    logic [PC_W-1:0] r_pendingPc, w_nextPendingPc;
    logic [31:0]     r_ifIdInstr, w_nextInstr;
    logic [PC_W-1:0] r_ifIdPc4, w_nextPc4;
    logic            r_ifIdValid, w_nextValid;
    logic [PC_W-1:0] w_pc4, w_redirTarget;
    logic            w_bufLoad, w_bufUnload, w_bufClear, w_bufFull;
    logic [31:0]     w_bufInstr;
    logic [PC_W-1:0] w_bufPc4;

    assign w_pc4         = r_fetchPc + PC_W'(PC_INC);
    assign w_redirTarget = redirect_pc & c_alignMask;
    assign imem_req      = (r_state == S_REQ) || (r_state == S_DRAIN);
    assign imem_addr     = r_fetchPc;

    fetch_skid_buf #(.PC_W(PC_W)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_bufLoad),
        .i_unload (w_bufUnload),
        .i_clear  (w_bufClear),
        .i_instr  (imem_rdata),
        .i_pc4    (w_pc4),
        .o_full   (w_bufFull),
        .o_instr  (w_bufInstr),
        .o_pc4    (w_bufPc4)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_fetchPc   <= RESET_PC;
            r_pendingPc <= RESET_PC;
            r_ifIdInstr <= NOP_INSTR;
            r_ifIdPc4   <= '0;
            r_ifIdValid <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_fetchPc   <= w_nextFetchPc;
            r_pendingPc <= w_nextPendingPc;
            r_ifIdInstr <= w_nextInstr;
            r_ifIdPc4   <= w_nextPc4;
            r_ifIdValid <= w_nextValid;
        end
    end

    always_comb begin
        w_nextState     = r_state;
        w_nextFetchPc   = r_fetchPc;
        w_nextPendingPc = r_pendingPc;
        w_nextInstr     = r_ifIdInstr;
        w_nextPc4       = r_ifIdPc4;
        w_nextValid     = r_ifIdValid;
        w_bufLoad       = 1'b0;
        w_bufUnload     = 1'b0;
        w_bufClear      = 1'b0;
        // A redirect overrides stall and any ack captured this cycle.
        if (redirect_en) begin
            w_nextValid = 1'b0;
            w_nextInstr = NOP_INSTR;
            w_bufClear  = 1'b1;
            case (r_state)
                S_REQ: begin
                    if (imem_ack) begin
                        w_nextFetchPc = w_redirTarget;
                    end else begin
                        w_nextPendingPc = w_redirTarget;
                        w_nextState     = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    w_nextPendingPc = w_redirTarget;
                    if (imem_ack) begin
                        w_nextFetchPc = w_redirTarget;
                        w_nextState   = S_REQ;
                    end
                end
                default: begin
                    w_nextFetchPc = w_redirTarget;
                    w_nextState   = S_REQ;
                end
            endcase
        end else begin
            case (r_state)
                S_IDLE: w_nextState = S_REQ;
                S_REQ: begin
                    if (imem_ack) begin
                        w_nextFetchPc = w_pc4;
                        if (!stall) begin
                            w_nextInstr = imem_rdata;
                            w_nextPc4   = w_pc4;
                            w_nextValid = 1'b1;
                        end else begin
                            w_bufLoad   = 1'b1;
                            w_nextState = S_HOLD;
                        end
                    end else if (!stall) begin
                        w_nextValid = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        w_nextInstr = w_bufInstr;
                        w_nextPc4   = w_bufPc4;
                        w_nextValid = w_bufFull;
                        w_bufUnload = 1'b1;
                        w_nextState = S_REQ;
                    end
                end
                S_DRAIN: begin
                    // Stale data is dropped; fetch resumes at the remembered target.
                    if (imem_ack) begin
                        w_nextFetchPc = r_pendingPc;
                        w_nextState   = S_REQ;
                    end
                end
            endcase
        end
    end

    assign if_id_instr = r_ifIdInstr;
    assign if_id_pc4   = r_ifIdPc4;
    assign if_id_valid = r_ifIdValid;

`ifdef FETCH_PERF_EN
    logic        w_fetchedInc, w_bubbleInc;
    logic [31:0] r_perfFetched, r_perfBubbles;

    assign w_fetchedInc = !redirect_en && !stall &&
                          (((r_state == S_REQ) && imem_ack) || ((r_state == S_HOLD) && w_bufFull));
    assign w_bubbleInc  = !stall && (redirect_en || ((r_state == S_REQ) && !imem_ack) ||
                                     ((r_state == S_HOLD) && !w_bufFull));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perfFetched <= '0;
            r_perfBubbles <= '0;
        end else begin
            if (w_fetchedInc) r_perfFetched <= r_perfFetched + 32'd1;
            if (w_bubbleInc)  r_perfBubbles <= r_perfBubbles + 32'd1;
        end
    end

    assign perf_fetched = r_perfFetched;
    assign perf_bubbles = r_perfBubbles;
`endif

endmodule
`default_nettype wire
